brr_stream_out: RTL and testbench

// Read-side sequencer for the bit-reverse ping-pong reorder buffer. It drains one

---
 rtl/brr_pkg.sv | 15 +
 rtl/skid_fifo2.sv | 43 ++++
 rtl/brr_stream_out.sv | 120 ++++++++++++
 tb/tb_brr_stream_out.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brr_pkg.sv
// Shared definitions for the bit-reverse reorder buffer read side.
package brr_pkg;

  localparam int BRR_DATA_WIDTH = 16;
  localparam int BRR_ADDR_WIDTH = 7;
  localparam int BRR_DEPTH      = 1 << BRR_ADDR_WIDTH;
  localparam int BRR_FCNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } brr_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs the reorder buffer's one-cycle read latency.
// The head entry is presented combinationally and only moves on a pop, so the
// output stays stable while the consumer stalls. The caller's credit logic
// guarantees that push is never asserted while both entries are occupied.
module skid_fifo2 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; storage is cleared so the stream outputs read 0 in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/brr_stream_out.sv
// Read-side sequencer for the bit-reverse ping-pong reorder buffer.
// Drains one natural-order frame per pass and presents it as a valid/ready
// stream with first/last markers. Reads are only issued when the skid FIFO
// plus the in-flight read can hold the result, so the FIFO never overflows
// and a continuously ready consumer sees one sample per clock.
module brr_stream_out
  import brr_pkg::*;
#(
  parameter int DATA_WIDTH = BRR_DATA_WIDTH,
  parameter int ADDR_WIDTH = BRR_ADDR_WIDTH,
  parameter int FCNT_WIDTH = BRR_FCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  brr_rd_en,
  input  logic [DATA_WIDTH-1:0] brr_data,
  input  logic                  brr_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  frame_done,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic                  err_underrun
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  brr_state_t            state;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  inflight;
  logic                  inflight_first;
  logic                  inflight_last;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH+1:0] fifo_dout;
  logic [2:0]            occupancy;
  logic                  credit_ok;
  logic                  pop;

  assign pop        = m_valid & m_ready;
  // A pop this cycle frees a slot for a read issued this cycle.
  assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok  = (occupancy < 3'd2);
  assign brr_rd_en  = (state == ST_READ) & credit_ok;
  assign m_valid    = (fifo_cnt != 2'd0);
  assign {m_first, m_last, m_data} = fifo_dout;
  assign frame_done = pop & m_last;

  // Frame sequencer: wait for a complete frame, issue DEPTH reads, then drain until last is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rd_idx       <= '0;
      err_underrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!brr_empty) begin
            state  <= ST_READ;
            rd_idx <= '0;
          end
        end
        ST_READ: begin
          if (brr_rd_en) begin
            rd_idx <= rd_idx + 1'b1;
            if (brr_empty && (rd_idx != '0)) begin
              err_underrun <= 1'b1;
            end
            if (rd_idx == LAST_IDX) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (frame_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In-flight read and its frame tags, aligned with the buffer's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight       <= 1'b0;
      inflight_first <= 1'b0;
      inflight_last  <= 1'b0;
    end else begin
      inflight       <= brr_rd_en;
      inflight_first <= brr_rd_en && (rd_idx == '0);
      inflight_last  <= brr_rd_en && (rd_idx == LAST_IDX);
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight),
    .pop  (pop),
    .din  ({inflight_first, inflight_last, brr_data}),
    .dout (fifo_dout),
    .cnt  (fifo_cnt)
  );

endmodule

// File: tb/tb_brr_stream_out.sv
// Testbench for brr_stream_out: models the reorder buffer as a source of
// consecutive sample values and checks the stream against the expected
// natural-order sequence and frame bookkeeping.
module tb_brr_stream_out;
  import brr_pkg::*;

  localparam int DW    = BRR_DATA_WIDTH;
  localparam int AW    = BRR_ADDR_WIDTH;
  localparam int FW    = BRR_FCNT_WIDTH;
  localparam int DEPTH = BRR_DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          brr_rd_en;
  logic [DW-1:0] brr_data;
  logic          brr_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_first;
  logic          m_last;
  logic          frame_done;
  logic [FW-1:0] frame_cnt;
  logic          err_underrun;

  brr_stream_out #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FCNT_WIDTH(FW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .brr_rd_en   (brr_rd_en),
    .brr_data    (brr_data),
    .brr_empty   (brr_empty),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_first     (m_first),
    .m_last      (m_last),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          rd_cnt;
  int          beat_cnt;
  int          frames_done;
  int          loaded;
  int          cyc;
  int          last_pop_cyc;
  int          first_pop_cyc;
  bit          seen_last;
  bit          exp_err;
  bit          force_empty;
  bit          rand_ready;
  bit          stall_prev;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_tags;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic reset_model();
    rd_cnt      = 0;
    beat_cnt    = 0;
    frames_done = 0;
    seen_last   = 1'b0;
    exp_err     = 1'b0;
    stall_prev  = 1'b0;
    force_empty = 1'b0;
  endtask

  task automatic drive_empty();
    brr_empty = force_empty || (rd_cnt >= loaded * DEPTH);
  endtask

  task automatic chk_all_zero();
    chk("rst_rd_en", 32'(brr_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_tags", 32'({m_first, m_last}), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
  endtask

  // One clock: check at the falling edge, then drive the next inputs just after the rising edge.
  task automatic step();
    logic rd_now;
    logic pop_now;
    bit   is_first;
    bit   is_last;
    int   issued;
    @(negedge clk);
    cyc++;
    rd_now   = brr_rd_en;
    pop_now  = m_valid & m_ready;
    is_first = ((beat_cnt % DEPTH) == 0);
    is_last  = ((beat_cnt % DEPTH) == DEPTH - 1);
    chk("underrun", 32'(err_underrun), 32'(exp_err));
    if (stall_prev) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_tags", 32'({m_first, m_last}), 32'(prev_tags));
    end
    if (rd_now) begin
      chk("credit", 32'((rd_cnt - beat_cnt - int'(pop_now)) < 2), 32'd1);
      if (force_empty && (rd_cnt % DEPTH) != 0) exp_err = 1'b1;
    end
    chk("frame_done", 32'(frame_done), 32'(pop_now && is_last));
    if (pop_now) begin
      chk("data", 32'(m_data), 32'((beat_cnt + 1) % (1 << DW)));
      chk("first", 32'(m_first), 32'(is_first));
      chk("last", 32'(m_last), 32'(is_last));
      chk("frame_cnt_at_pop", 32'(frame_cnt), 32'(frames_done % (1 << FW)));
      if (is_first) begin
        if (seen_last) chk("gap", 32'((cyc - last_pop_cyc - 1) >= 2), 32'd1);
        first_pop_cyc = cyc;
      end
      if (is_last) begin
        last_pop_cyc = cyc;
        seen_last    = 1'b1;
        frames_done++;
      end
      beat_cnt++;
    end
    stall_prev = m_valid && !m_ready;
    prev_data  = m_data;
    prev_tags  = {m_first, m_last};
    issued     = rd_cnt;
    if (rd_now) rd_cnt++;
    @(posedge clk);
    #1;
    if (rd_now) brr_data = DW'(issued + 1);
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_empty();
  endtask

  task automatic run_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beat_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("beats_reached", 32'(beat_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    reset_model();
    loaded    = 0;
    m_ready   = 1'b1;
    brr_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    m_ready    = 1'b0;
    brr_data   = '0;
    brr_empty  = 1'b1;
    loaded     = 0;
    rand_ready = 1'b0;
    cyc        = 0;
    last_pop_cyc  = 0;
    first_pop_cyc = 0;
    prev_data  = '0;
    prev_tags  = '0;
    reset_model();

    // Power-on reset
    do_reset();

    // Single frame at full rate
    loaded = 1;
    drive_empty();
    run_beats(DEPTH, 400);
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("single_throughput", 32'(last_pop_cyc - first_pop_cyc), 32'(DEPTH - 1));

    // Random backpressure over two frames
    rand_ready = 1'b1;
    loaded = 3;
    drive_empty();
    run_beats(3 * DEPTH, 2000);
    chk("backpressure_frame_cnt", 32'(frame_cnt), 32'd3);

    // Two frames back to back at full rate
    rand_ready = 1'b0;
    m_ready = 1'b1;
    loaded = 5;
    drive_empty();
    run_beats(5 * DEPTH, 700);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("no_underrun_yet", 32'(err_underrun), 32'd0);

    // Reset in the middle of a frame, then a fresh frame from index 0
    loaded = 6;
    drive_empty();
    run_beats(5 * DEPTH + 50, 200);
    do_reset();
    loaded = 1;
    drive_empty();
    run_beats(DEPTH, 400);
    chk("after_reset_frame_cnt", 32'(frame_cnt), 32'd1);

    // Underrun at read index 40 of the second frame, sticky afterwards
    loaded = 4;
    drive_empty();
    n = 0;
    while (rd_cnt < DEPTH + 40 && n < 400) begin
      step();
      n++;
    end
    chk("reach_idx40", 32'(rd_cnt), 32'(DEPTH + 40));
    force_empty = 1'b1;
    drive_empty();
    step();
    force_empty = 1'b0;
    drive_empty();
    step();
    chk("underrun_set", 32'(err_underrun), 32'd1);
    run_beats(4 * DEPTH, 1000);
    chk("underrun_sticky", 32'(err_underrun), 32'd1);

    // 256 frames: the frame counter wraps back to 0
    do_reset();
    loaded = 256;
    drive_empty();
    run_beats(256 * DEPTH, 36000);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap_no_underrun", 32'(err_underrun), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
